// File: rtl/spi_regfile.sv
// rtl/spi_regfile.sv - SPI register-file command layer: command/data frame protocol over four control
// and four status words.
module spi_regfile #(
  parameter int unsigned     size = 8,
  parameter logic [size-1:0] ID   = 8'hC1,
  parameter logic [15:0]     TMO  = 16'd50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scs,
  input  logic [size-1:0]   rxd,
  output logic [size-1:0]   txd,
  output logic [4*size-1:0] ctl,
  input  logic [4*size-1:0] sta,
  output logic              wr_stb,
  output logic [1:0]        wr_adr,
  output logic              err
);

  localparam int AW = size - 1;

  localparam logic [1:0] S_CMD     = 2'd0;
  localparam logic [1:0] S_DATA_WR = 2'd1;
  localparam logic [1:0] S_DATA_RD = 2'd2;

  logic              xcs_q;
  logic              rx_q;
  logic              frame_end;
  logic [1:0]        state_q, state_d;
  logic [AW-1:0]     adr_q, adr_d;
  logic [size-1:0]   txd_q, txd_d;
  logic [4*size-1:0] ctl_q, ctl_d;
  logic              wr_stb_q, wr_stb_d;
  logic [1:0]        wr_adr_q, wr_adr_d;
  logic              err_q, err_d;
  logic [15:0]       cnt_q, cnt_d;

  logic [AW-1:0]     rx_adr;
  logic              rx_bad;
  logic              adr_bad;
  logic [size-1:0]   rd_val;

  // The shifter updates rxd in the frame-end cycle, so the word is consumed one cycle later.
  assign frame_end = xcs_q & ~scs;

  assign rx_adr  = rxd[AW-1:0];
  assign rx_bad  = (rx_adr > AW'(7));
  assign adr_bad = (adr_q > AW'(7));

  always_comb begin
    if (rx_bad) begin
      rd_val = '0;
    end else if (rx_adr[2]) begin
      rd_val = sta[size*rx_adr[1:0] +: size];
    end else begin
      rd_val = ctl_q[size*rx_adr[1:0] +: size];
    end
  end

  always_comb begin
    state_d  = state_q;
    adr_d    = adr_q;
    txd_d    = txd_q;
    ctl_d    = ctl_q;
    wr_stb_d = 1'b0;
    wr_adr_d = wr_adr_q;
    err_d    = 1'b0;
    cnt_d    = cnt_q;
    case (state_q)
      S_CMD: begin
        if (rx_q) begin
          adr_d = rx_adr;
          cnt_d = '0;
          if (rxd[size-1]) begin
            state_d = S_DATA_WR;
          end else begin
            state_d = S_DATA_RD;
            txd_d   = rd_val;
            err_d   = rx_bad;
          end
        end
      end
      S_DATA_WR, S_DATA_RD: begin
        cnt_d = cnt_q + 16'd1;
        // A data word arriving in the expiry cycle wins over the timeout.
        if (rx_q) begin
          if (state_q == S_DATA_WR) begin
            if (adr_q < AW'(4)) begin
              ctl_d[size*adr_q[1:0] +: size] = rxd;
              wr_stb_d = 1'b1;
              wr_adr_d = adr_q[1:0];
            end else if (adr_bad) begin
              err_d = 1'b1;
            end
          end
          state_d = S_CMD;
          txd_d   = ID;
        end else if (cnt_q == TMO - 16'd1) begin
          state_d = S_CMD;
          txd_d   = ID;
          err_d   = 1'b1;
        end
      end
      default: begin
        state_d = S_CMD;
        txd_d   = ID;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xcs_q    <= 1'b0;
      rx_q     <= 1'b0;
      state_q  <= S_CMD;
      adr_q    <= '0;
      txd_q    <= ID;
      ctl_q    <= '0;
      wr_stb_q <= 1'b0;
      wr_adr_q <= 2'd0;
      err_q    <= 1'b0;
      cnt_q    <= 16'd0;
    end else begin
      xcs_q    <= scs;
      rx_q     <= frame_end;
      state_q  <= state_d;
      adr_q    <= adr_d;
      txd_q    <= txd_d;
      ctl_q    <= ctl_d;
      wr_stb_q <= wr_stb_d;
      wr_adr_q <= wr_adr_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign txd    = txd_q;
  assign ctl    = ctl_q;
  assign wr_stb = wr_stb_q;
  assign wr_adr = wr_adr_q;
  assign err    = err_q;

endmodule

// File: tb/tb_spi_regfile.sv
// tb/tb_spi_regfile.sv - Directed bench for spi_regfile with a queue of expected shifted-out words.
module tb_spi_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        scs = 1'b0;
  logic [7:0]  rxd = 8'h00;
  logic [7:0]  txd;
  logic [31:0] ctl;
  logic [31:0] sta = 32'h0;
  logic        wr_stb;
  logic [1:0]  wr_adr;
  logic        err;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int err_cnt = 0;
  logic [7:0] exp_q[$];

  spi_regfile #(.size(8), .ID(8'hC1), .TMO(16'd20)) dut (
    .clk    (clk),
    .rst    (rst),
    .scs    (scs),
    .rxd    (rxd),
    .txd    (txd),
    .ctl    (ctl),
    .sta    (sta),
    .wr_stb (wr_stb),
    .wr_adr (wr_adr),
    .err    (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_stb === 1'b1) wr_cnt++;
    if (err === 1'b1) err_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pop_exp();
    if (exp_q.size() == 0) return 8'hxx;
    return exp_q.pop_front();
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One frame: the shifter loads txd at the scs rise and presents the received word at the scs fall.
  task automatic frame(input logic [7:0] word, input logic [7:0] next_exp, input int hi);
    @(negedge clk);
    check("shift_out", {24'd0, txd}, {24'd0, pop_exp()});
    scs = 1'b1;
    repeat (hi) @(negedge clk);
    scs = 1'b0;
    rxd = word;
    exp_q.push_back(next_exp);
  endtask

  initial begin
    int snap_wr;
    int snap_err;
    int err_first;
    logic [7:0] wv;
    logic [7:0] wv_m[4];
    logic [7:0] rexp;

    wait_cyc(2);
    check("rst_txd", {24'd0, txd}, 32'h0000_00C1);
    check("rst_ctl", ctl, 32'h0);
    check("rst_wr_stb", {31'd0, wr_stb}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b1;
    exp_q.push_back(8'hC1);
    wait_cyc(2);

    // Write 0x5A to ctl[2]
    snap_wr = wr_cnt;
    frame(8'h82, 8'hC1, 8);
    wait_cyc(2);
    frame(8'h5A, 8'hC1, 3);
    wait_cyc(1);
    check("wr_e1_stb", {31'd0, wr_stb}, 32'd0);
    check("wr_e1_ctl", {24'd0, ctl[23:16]}, 32'h0);
    wait_cyc(1);
    check("wr_e2_stb", {31'd0, wr_stb}, 32'd1);
    check("wr_e2_adr", {30'd0, wr_adr}, 32'd2);
    check("wr_e2_ctl", ctl, 32'h005A_0000);
    wait_cyc(1);
    check("wr_e3_stb", {31'd0, wr_stb}, 32'd0);
    check("wr_count", snap_wr + 1, wr_cnt);

    // Read back ctl[2]
    frame(8'h02, 8'h5A, 5);
    wait_cyc(2);
    frame(8'h00, 8'hC1, 2);
    wait_cyc(2);

    // Status snapshot taken in E+1
    sta = 32'h0000_3C00;
    frame(8'h05, 8'h3C, 4);
    wait_cyc(2);
    sta = 32'h0000_FF00;
    frame(8'h00, 8'hC1, 4);
    wait_cyc(2);
    sta = 32'h0;

    // Bad read address
    snap_err = err_cnt;
    frame(8'h09, 8'h00, 2);
    wait_cyc(1);
    check("bad_e1_err", {31'd0, err}, 32'd0);
    wait_cyc(1);
    check("bad_e2_err", {31'd0, err}, 32'd1);
    frame(8'h00, 8'hC1, 2);
    wait_cyc(3);
    check("bad_err_count", snap_err + 1, err_cnt);

    // Write to a status address is ignored
    snap_wr = wr_cnt;
    snap_err = err_cnt;
    frame(8'h86, 8'hC1, 3);
    wait_cyc(2);
    frame(8'h77, 8'hC1, 3);
    wait_cyc(4);
    check("ign_ctl", ctl, 32'h005A_0000);
    check("ign_wr_count", snap_wr, wr_cnt);
    check("ign_err_count", snap_err, err_cnt);

    // Reset during the data frame of a write
    frame(8'h81, 8'hC1, 4);
    wait_cyc(2);
    @(negedge clk);
    check("rst_mid_shift", {24'd0, txd}, {24'd0, pop_exp()});
    scs = 1'b1;
    wait_cyc(2);
    rxd = 8'hEE;
    rst = 1'b0;
    wait_cyc(1);
    check("rst_mid_ctl", ctl, 32'h0);
    check("rst_mid_txd", {24'd0, txd}, 32'h0000_00C1);
    check("rst_mid_wr_stb", {31'd0, wr_stb}, 32'd0);
    check("rst_mid_err", {31'd0, err}, 32'd0);
    scs = 1'b0;
    wait_cyc(2);
    rst = 1'b1;
    exp_q.delete();
    exp_q.push_back(8'hC1);
    wait_cyc(2);
    frame(8'h01, 8'h00, 3);
    wait_cyc(2);
    frame(8'h00, 8'hC1, 3);
    wait_cyc(2);

    // Timeout on a write command with no data frame
    snap_wr = wr_cnt;
    snap_err = err_cnt;
    err_first = 0;
    frame(8'h81, 8'hC1, 5);
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (err === 1'b1 && err_first == 0) err_first = k;
    end
    check("tmo_err_cycle", err_first, 22);
    check("tmo_err_count", snap_err + 1, err_cnt);
    check("tmo_txd", {24'd0, txd}, 32'h0000_00C1);
    frame(8'h81, 8'hC1, 3);
    wait_cyc(2);
    frame(8'hAA, 8'hC1, 3);
    wait_cyc(2);
    check("tmo_after_adr", {30'd0, wr_adr}, 32'd1);
    check("tmo_after_ctl", ctl, 32'h0000_AA00);
    wait_cyc(2);
    check("tmo_wr_count", snap_wr + 1, wr_cnt);

    // Timeout on a read command restores the ID word
    sta = 32'h0000_0055;
    frame(8'h04, 8'h55, 3);
    wait_cyc(2);
    check("tmo_rd_txd_pre", {24'd0, txd}, 32'h0000_0055);
    wait_cyc(20);
    check("tmo_rd_txd_post", {24'd0, txd}, 32'h0000_00C1);
    void'(pop_exp());
    exp_q.push_back(8'hC1);
    wait_cyc(2);

    // Data frame end lands in the expiry cycle
    snap_err = err_cnt;
    frame(8'h82, 8'hC1, 3);
    wait_cyc(2);
    frame(8'h33, 8'hC1, 17);
    wait_cyc(1);
    check("race_e1_stb", {31'd0, wr_stb}, 32'd0);
    wait_cyc(1);
    check("race_e2_stb", {31'd0, wr_stb}, 32'd1);
    check("race_ctl", ctl, 32'h0033_AA00);
    wait_cyc(10);
    check("race_err_count", snap_err, err_cnt);

    // Back-to-back write/read on every address
    sta = $urandom;
    snap_wr = wr_cnt;
    for (int a = 0; a < 8; a++) begin
      wv = 8'($urandom);
      frame({1'b1, 7'(a)}, 8'hC1, 1 + a % 3);
      wait_cyc(2);
      frame(wv, 8'hC1, 2 + a % 4);
      if (a < 4) wv_m[a] = wv;
      wait_cyc(2);
      rexp = (a < 4) ? wv_m[a] : sta[8*(a-4) +: 8];
      frame({1'b0, 7'(a)}, rexp, 1 + a % 2);
      wait_cyc(2);
      frame(8'h00, 8'hC1, 3);
      wait_cyc(2);
    end
    frame(8'h80, 8'hC1, 2);
    wait_cyc(3);
    check("b2b_ctl", ctl, {wv_m[3], wv_m[2], wv_m[1], wv_m[0]});
    check("b2b_wr_count", snap_wr + 4, wr_cnt);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
